mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous instruction/data memory between two requesters: the instruction-fetch port and the load/store data port.
- Sits between the datapath/control pair and the memory. It replaces the dual-port memory interface so the core can run multicycle or pipelined against one physical RAM.
- Arbitration is per cycle with fixed data priority and an anti-starvation timer for fetch. Each grant produces exactly one valid response one cycle later.

Parameters:
- ADDR_W, 16, byte address width of both requesters and the memory.
- DATA_W, 32, data word width.
- MAX_WAIT, 4, consecutive cycles fetch may be denied before it gets forced priority; 0 means data always wins.
- CNT_W, 3, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle (combinational).
- if_valid  out  1  fetch read data valid (registered).
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle (combinational).
- d_valid  out  1  load data valid or store complete (registered).
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: if_valid=0, d_valid=0, wait_cnt=0, pend=NONE.
- While rst=1, if_gnt=d_gnt=mem_en=mem_we=0 regardless of requests.

Arbitration (combinational, every cycle):
- At most one grant per cycle; mem_en = if_gnt | d_gnt.
- Only d_req: d_gnt=1. Only if_req: if_gnt=1.
- Both asserted: d_gnt=1, unless MAX_WAIT!=0 and wait_cnt>=MAX_WAIT, in which case if_gnt=1.
- On d_gnt: mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata.
- On if_gnt: mem_addr=if_addr, mem_we=0.
- No grant: mem_addr/mem_wdata=0, mem_we=0.

Wait counter:
- if_req=1 and if_gnt=0: increment, saturating at all-ones.
- if_gnt=1 or if_req=0: clear to 0.

Response tracking:
- pend register encodes NONE, FETCH, DATA_RD, DATA_WR and is loaded every cycle from the grant issued.
- if_valid = (pend==FETCH). d_valid = (pend==DATA_RD or DATA_WR).
- Responses arrive exactly 1 cycle after the grant; there is no stall path.
- if_rdata = d_rdata = mem_rdata (shared bus); the valid signals select the owner.
- Back-to-back: a new grant may issue in the same cycle as the previous response's valid. Full throughput is 1 access/cycle.
- Requester handshake: req/addr/wdata must be held stable until gnt. After gnt, the requester may drop req or present a new request the next cycle.
- rst asserted mid-operation: the outstanding response is discarded (no valid pulse after reset). A store granted in the reset cycle is not performed, since mem_en is forced to 0.

Decomposition:
- Shared package holds the pend-state encoding (NONE=2'd0, FETCH=2'd1, DATA_RD=2'd2, DATA_WR=2'd3) and the default ADDR_W/DATA_W constants used by the memory and datapath.
- One natural sub-module: arb_starve_timer, containing the wait counter and the force-fetch compare. The rest stays flat.

Test Plan:
- Reset: rst=1 for 2 cycles with if_req=d_req=1 -> no gnt, mem_en=0. First cycle after release: d_gnt=1, if_valid=d_valid=0.
- Lone fetch: if_req=1, if_addr=0x0010; memory holds 0x00500093 -> if_gnt same cycle, mem_addr=0x0010. Next cycle if_valid=1, if_rdata=0x00500093.
- Store then load: d_req store addr 0x0100, wdata 0xDEADBEEF. Then load addr 0x0100 -> d_valid after each. Load returns 0xDEADBEEF, with mem_we=1 only in the store grant cycle.
- Contention: if_req and d_req held high continuously with MAX_WAIT=4 -> data granted 4 cycles, fetch forced on the 5th, then wait_cnt=0 and data resumes. Pattern repeats D,D,D,D,F.
- MAX_WAIT=0: both requests held 10 cycles -> if_gnt never asserted, wait_cnt saturates at 7.
- Reset mid-read: fetch granted at cycle N, rst=1 at cycle N+1 -> if_valid stays 0 at N+1 and afterwards until a new grant.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the single-port memory arbiter and the datapath/memory
// that sit around it.
//   - pend_t    : which response is due on the cycle after a grant
//   - gnt_sel_t : which requester owns the memory this cycle
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths used by core and memory
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    PEND_NONE    = 2'd0,
    PEND_FETCH   = 2'd1,
    PEND_DATA_RD = 2'd2,
    PEND_DATA_WR = 2'd3
  } pend_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2
  } gnt_sel_t;

  // A data response covers both load data and store completion.
  function automatic logic pend_is_data(input pend_t p);
    return (p == PEND_DATA_RD) || (p == PEND_DATA_WR);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_timer.sv
// arb_starve_timer: counts consecutive cycles in which the fetch port is
// requesting but not granted, and raises force_fetch once that count reaches
// MAX_WAIT so that fetch wins the next contended cycle.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   if_req       : fetch request from the core
//   if_gnt       : fetch grant issued by the arbiter this cycle
//   wait_cnt     : current denial count (saturates at all-ones)
//   force_fetch  : fetch takes priority over data when both request
module arb_starve_timer #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic             if_gnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             force_fetch
);

  // MAX_WAIT must fit in CNT_W bits, otherwise the threshold is truncated.
  localparam logic [CNT_W:0] MAX_WAIT_C = (CNT_W+1)'(MAX_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (if_req && !if_gnt) begin
      // Keep counting while denied, but never wrap back to a small value.
      if (wait_cnt != {CNT_W{1'b1}}) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  generate
    if (MAX_WAIT == 0) begin : g_no_force
      // Data always wins; the counter still runs so starvation is observable.
      assign force_fetch = 1'b0;
    end else begin : g_force
      assign force_fetch = ({1'b0, wait_cnt} >= MAX_WAIT_C);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the
// instruction-fetch port and the load/store data port. Data has fixed priority;
// fetch is forced through after MAX_WAIT consecutive denials. Every grant
// yields exactly one valid pulse on the owning port one cycle later.
//
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   if_req/if_addr             : fetch request, held until if_gnt
//   if_gnt                     : fetch accepted this cycle (combinational)
//   if_valid/if_rdata          : fetch data return
//   d_req/d_we/d_addr/d_wdata  : data request, held until d_gnt
//   d_gnt                      : data accepted this cycle (combinational)
//   d_valid/d_rdata            : load data or store completion
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : single RAM port
//
// Response tracker states:
//   state        | meaning
//   PEND_NONE    | no access last cycle, no valid this cycle
//   PEND_FETCH   | fetch read last cycle, if_valid this cycle
//   PEND_DATA_RD | load last cycle, d_valid with read data this cycle
//   PEND_DATA_WR | store last cycle, d_valid as completion this cycle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 3
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  gnt_sel_t         gnt_sel;
  pend_t            pend;
  pend_t            pend_next;
  logic             force_fetch;
  logic [CNT_W-1:0] wait_cnt;

  arb_starve_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_gnt      (if_gnt),
    .wait_cnt    (wait_cnt),
    .force_fetch (force_fetch)
  );

  // Per-cycle arbitration. Reset blocks every grant so that nothing, in
  // particular a store, reaches the RAM while rst is high.
  always_comb begin
    gnt_sel = GNT_NONE;
    if (!rst) begin
      if (d_req && !(if_req && force_fetch)) begin
        gnt_sel = GNT_DATA;
      end else if (if_req) begin
        gnt_sel = GNT_FETCH;
      end
    end
  end

  assign if_gnt = (gnt_sel == GNT_FETCH);
  assign d_gnt  = (gnt_sel == GNT_DATA);

  // Response tracker: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= PEND_NONE;
    end else begin
      pend <= pend_next;
    end
  end

  // Response tracker: next state is simply the grant issued this cycle.
  always_comb begin
    pend_next = PEND_NONE;
    unique case (gnt_sel)
      GNT_FETCH: pend_next = PEND_FETCH;
      GNT_DATA:  pend_next = d_we ? PEND_DATA_WR : PEND_DATA_RD;
      default:   pend_next = PEND_NONE;
    endcase
  end

  // Outputs: memory port mux and response valids.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (gnt_sel)
      GNT_DATA: begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end
      GNT_FETCH: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      default: begin
      end
    endcase
  end

  // A response still outstanding when rst rises is dropped rather than
  // reported, so the valids are masked during reset as well as cleared by it.
  assign if_valid = !rst && (pend == PEND_FETCH);
  assign d_valid  = !rst && pend_is_data(pend);

  // One shared read bus; the valids say who owns it.
  assign if_rdata = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
